// File: rtl/cross_bar_slave_mem_pkg.sv
// Shared crossbar types plus the slave memory model's command codes and FSM states.
package cross_bar_slave_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } slave_mem_state_t;

endpackage

// File: rtl/cross_bar_slave_mem_if.sv
// Crossbar slave-port bus: request side driven by the crossbar, ack/rdata by the slave.
interface cross_bar_slave_mem_if;
    import cross_bar_slave_mem_pkg::*;

    logic  req;
    addr_t addr;
    logic  cmd;
    data_t wdata;
    logic  ack;
    data_t rdata;

    modport master (
        output req, addr, cmd, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, addr, cmd, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/cross_bar_slave_mem.sv
// Word-addressed slave memory with a programmable number of wait states before ack.
module cross_bar_slave_mem
    import cross_bar_slave_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  aresetn,
    cross_bar_slave_mem_if.slave  bus
);

    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    slave_mem_state_t state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cmd_q, cmd_d;
    data_t            wdata_q, wdata_d;
    logic             ack_q, ack_d;
    data_t            rdata_q, rdata_d;
    logic [IDX_W-1:0] live_idx;

    data_t mem [MEM_DEPTH];

    assign live_idx = bus.addr[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    idx_d   = live_idx;
                    cmd_d   = bus.cmd;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered: precompute what the RESP cycle will present.
        ack_d   = (state_d == RESP);
        rdata_d = (state_d == RESP && cmd_d == CMD_READ) ? mem[idx_d] : '0;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cmd_q   <= CMD_READ;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Write commits at the end of RESP, so a following capture already sees it.
    always_ff @(posedge clk) begin
        if (state_q == RESP && cmd_q == CMD_WRITE) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

    a_ack_single: assert property (@(posedge clk) disable iff (!aresetn)
        bus.ack |=> !bus.ack);

    a_ack_needs_req: assert property (@(posedge clk) disable iff (!aresetn)
        bus.ack |-> bus.req);

    a_capture_stable: assert property (@(posedge clk) disable iff (!aresetn)
        (state_q == WAIT && bus.req) |->
            (idx_q == live_idx && cmd_q == bus.cmd && wdata_q == bus.wdata));

endmodule

// File: tb/tb_cross_bar_slave_mem.sv
// Directed bench: one instance with two wait states, one with none, hand-computed expectations.
module tb_cross_bar_slave_mem;
    import cross_bar_slave_mem_pkg::*;

    localparam int unsigned WC_A = 2;
    localparam int unsigned WC_B = 0;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    cross_bar_slave_mem_if bus_a ();
    cross_bar_slave_mem_if bus_b ();

    logic  req_s   [2];
    logic  cmd_s   [2];
    addr_t addr_s  [2];
    data_t wdata_s [2];
    logic  ack_s   [2];
    data_t rdata_s [2];

    assign bus_a.req   = req_s[0];
    assign bus_a.cmd   = cmd_s[0];
    assign bus_a.addr  = addr_s[0];
    assign bus_a.wdata = wdata_s[0];
    assign ack_s[0]    = bus_a.ack;
    assign rdata_s[0]  = bus_a.rdata;

    assign bus_b.req   = req_s[1];
    assign bus_b.cmd   = cmd_s[1];
    assign bus_b.addr  = addr_s[1];
    assign bus_b.wdata = wdata_s[1];
    assign ack_s[1]    = bus_b.ack;
    assign rdata_s[1]  = bus_b.rdata;

    cross_bar_slave_mem #(.MEM_DEPTH(256), .WAIT_CYCLES(WC_A)) u_dut_a (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus_a.slave)
    );

    cross_bar_slave_mem #(.MEM_DEPTH(256), .WAIT_CYCLES(WC_B)) u_dut_b (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus_b.slave)
    );

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int last_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Starts at a negedge; returns at the negedge after the ack cycle.
    task automatic xfer(input int d, input logic c, input addr_t a, input data_t wd,
                        input bit hold, input int exp_lat, input data_t exp_rd,
                        input string tag);
        int lat = 0;
        bit got = 1'b0;
        req_s[d]   = 1'b1;
        cmd_s[d]   = c;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack_s[d]) got = 1'b1;
            else check_eq({tag, "_rdata_wait"}, rdata_s[d], 32'h0);
        end
        last_ack = cyc;
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_rdata"}, rdata_s[d], exp_rd);
        @(negedge clk);
        check_eq({tag, "_ack_pulse"}, 32'(ack_s[d]), 32'h0);
        check_eq({tag, "_rdata_after"}, rdata_s[d], 32'h0);
        if (!hold) req_s[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev_ack;
        for (int i = 0; i < 2; i++) begin
            req_s[i]   = 1'b0;
            cmd_s[i]   = CMD_READ;
            addr_s[i]  = '0;
            wdata_s[i] = '0;
        end
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ack",   32'(ack_s[0]), 32'h0);
        check_eq("rst_rdata", rdata_s[0], 32'h0);
        check_eq("rst_state", 32'(u_dut_a.state_q), 32'(IDLE));
        check_eq("rst_cnt",   32'(u_dut_a.cnt_q), 32'h0);
        check_eq("rst_idx",   32'(u_dut_a.idx_q), 32'h0);
        aresetn = 1'b1;
        @(negedge clk);

        // Two wait states: ack lands three cycles after the request is seen.
        xfer(0, CMD_WRITE, 32'h10, 32'hDEADBEEF, 1'b0, 3, 32'h0, "a_w10");
        xfer(0, CMD_READ,  32'h10, 32'h0,        1'b0, 3, 32'hDEADBEEF, "a_r10");

        // Zero wait states: ack one cycle after the request.
        xfer(1, CMD_WRITE, 32'h04, 32'h12345678, 1'b0, 1, 32'h0, "b_w04");
        xfer(1, CMD_READ,  32'h04, 32'h0,        1'b0, 1, 32'h12345678, "b_r04");

        // Back-to-back with req held: acks every WC_A+2 = 4 cycles.
        prev_ack = 0;
        for (int i = 0; i < 8; i++) begin
            automatic logic  c  = (i < 4) ? CMD_WRITE : CMD_READ;
            automatic addr_t a  = addr_t'(32'((i % 4) * 4));
            automatic data_t wd = (i < 4) ? data_t'(i + 1) : 32'h0;
            automatic data_t rd = (i < 4) ? 32'h0 : data_t'((i % 4) + 1);
            xfer(0, c, a, wd, (i < 7), 3, rd, $sformatf("b2b%0d", i));
            if (i > 0) check_eq($sformatf("b2b%0d_spacing", i), 32'(last_ack - prev_ack), 32'd4);
            prev_ack = last_ack;
        end

        // 0x400 aliases word 0 in a 256-word memory.
        xfer(0, CMD_WRITE, 32'h400, 32'hA5A5A5A5, 1'b0, 3, 32'h0, "alias_w");
        xfer(0, CMD_READ,  32'h000, 32'h0,        1'b0, 3, 32'hA5A5A5A5, "alias_r");

        // Abort during WAIT leaves memory untouched.
        xfer(0, CMD_WRITE, 32'h20, 32'h1, 1'b0, 3, 32'h0, "abort_pre");
        req_s[0] = 1'b1; cmd_s[0] = CMD_WRITE; addr_s[0] = 32'h20; wdata_s[0] = 32'hFFFFFFFF;
        @(negedge clk);
        check_eq("abort_in_wait", 32'(u_dut_a.state_q), 32'(WAIT));
        req_s[0] = 1'b0;
        @(negedge clk);
        check_eq("abort_state", 32'(u_dut_a.state_q), 32'(IDLE));
        check_eq("abort_ack0",  32'(ack_s[0]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("abort_noack%0d", i), 32'(ack_s[0]), 32'h0);
        end
        xfer(0, CMD_READ, 32'h20, 32'h0, 1'b0, 3, 32'h1, "abort_r20");

        // Reset pulse in WAIT drops the pending write.
        xfer(0, CMD_WRITE, 32'h30, 32'h0, 1'b0, 3, 32'h0, "rst_pre");
        req_s[0] = 1'b1; cmd_s[0] = CMD_WRITE; addr_s[0] = 32'h30; wdata_s[0] = 32'h55;
        @(negedge clk);
        check_eq("rst_in_wait", 32'(u_dut_a.state_q), 32'(WAIT));
        aresetn  = 1'b0;
        req_s[0] = 1'b0;
        #1;
        check_eq("rst_async_ack",   32'(ack_s[0]), 32'h0);
        check_eq("rst_async_rdata", rdata_s[0], 32'h0);
        check_eq("rst_async_state", 32'(u_dut_a.state_q), 32'(IDLE));
        @(negedge clk);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_noack%0d", i), 32'(ack_s[0]), 32'h0);
        end
        xfer(0, CMD_READ, 32'h30, 32'h0, 1'b0, 3, 32'h0, "rst_r30");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cross_bar_slave_mem.md
Name: cross_bar_slave_mem

Overview:
- Slave-side memory model that sits directly downstream of one crossbar slave port.
- It consumes that port's req/addr/cmd/wdata and returns ack/rdata.
- It provides word-addressed storage with a parameterised number of wait states, so crossbar arbitration and stall paths can be exercised.
- One instance per slave port in the system-level bench and in FPGA bring-up.

Parameters:
- MEM_DEPTH, 256, number of DATA_W-bit words; must be a power of two, at least 2.
- WAIT_CYCLES, 2, wait states inserted between request capture and ack; range 0..15.
- IDX_W, $clog2(MEM_DEPTH), localparam, width of the word index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- aresetn  input  1  reset, asynchronous, active-low.
- req  input  1  request from the crossbar slave port.
- addr  input  ADDR_W (addr_t)  byte address; word index = addr[IDX_W+1:2].
- cmd  input  1  0 = read, 1 = write.
- wdata  input  DATA_W (data_t)  write data.
- ack  output  1  completion pulse; exactly one cycle per accepted request.
- rdata  output  DATA_W (data_t)  read data; valid only in a read ack cycle.

Behaviour:
- Bus protocol:
  - A transfer completes in the cycle where req=1 and ack=1.
  - The requester holds req/addr/cmd/wdata stable from req assertion until ack.
  - For reads, rdata is valid in the ack cycle.
- Reset (aresetn=0, asynchronous):
  - state=IDLE, ack=0, rdata=0, wait counter=0, capture registers=0.
  - Memory array is not reset; contents are undefined until written.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - If req=1, capture addr index, cmd and wdata.
    - Load counter with WAIT_CYCLES-1.
    - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT:
    - If req=0 (protocol abort), go to IDLE; no memory write occurs and no ack is issued.
    - Else if counter==0, go to RESP; else decrement the counter.
  - RESP:
    - ack=1 for this one cycle, then unconditionally go to IDLE.
    - Read: rdata = mem[captured index].
    - Write: mem[captured index] <= captured wdata at the end of this cycle; rdata=0.
- Latency: req first seen high in IDLE at cycle T gives ack at cycle T+1+WAIT_CYCLES.
- ack and rdata are registered outputs, with no combinational path from inputs.
- Throughput: after RESP the FSM spends at least one cycle in IDLE, so back-to-back requests give one transfer per WAIT_CYCLES+2 cycles.
  - req still high in the cycle immediately after ack is treated as a new request.
- rdata is 0 in every cycle where ack=0.
- Address bits above IDX_W+1 and addr[1:0] are ignored; out-of-range addresses alias. The crossbar has already decoded the slave select.
- Read-after-write to the same word in consecutive transfers returns the new data, because the write commits in RESP before the next capture.
- Reset asserted mid-transfer: the pending transfer is dropped, ack does not fire, and no partial write occurs.
- Assertions (bench/sim only):
  - ack never high in two consecutive cycles.
  - ack never high while req=0.
  - Captured fields equal the live inputs while in WAIT.

Decomposition:
- Additions to cross_bar_pkg:
  - CMD_READ=1'b0 and CMD_WRITE=1'b1 constants.
  - slave_mem_state_t enum {IDLE, WAIT, RESP}.
  - Reuse of addr_t, data_t, ADDR_W, DATA_W.
- Single module, no sub-module needed; the storage is an inferred array in the same file.

Test Plan:
- WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10 (req high at T) -> ack exactly at T+3 with rdata=0. Then read 0x10 -> ack 3 cycles after req and rdata=0xDEADBEEF in the ack cycle.
- WAIT_CYCLES=0: read after write to addr 0x04 with data 0x12345678 -> each ack 1 cycle after req; read returns 0x12345678.
- Back-to-back transfers: req held high across 4 writes to 0x0,0x4,0x8,0xC (data 1..4), then 4 reads -> 8 single-cycle ack pulses spaced WAIT_CYCLES+2 apart; reads return 1,2,3,4.
- Aliasing with MEM_DEPTH=256: write 0xA5A5A5A5 to addr 0x400, read addr 0x000 -> 0xA5A5A5A5.
- Abort: req drops in WAIT during a write of 0xFFFFFFFF to 0x20 that was preceded by a write of 0x1 -> no ack, FSM back in IDLE the next cycle; a later read of 0x20 returns 0x1.
- Reset mid-WAIT: aresetn low for 1 cycle during a write of 0x55 to 0x30 -> ack=0 and rdata=0 immediately (asynchronous), no ack afterwards; a later read of 0x30 returns the previously written 0x0.
